// File: rtl/calc_key_sequencer_if.sv
// Keypad-to-datapath bundle for calc_key_sequencer: key inputs, datapath
// strobes, display/status outputs and a state debug tap.
interface calc_key_sequencer_if;
  // Handshakes: key_valid is a level held while a key is down; the sequencer
  // acts on it once per press. dp_a_load/dp_b_load/dp_start are single-cycle
  // strobes with no back-pressure. dp_done is a single-cycle pulse that
  // qualifies dp_result and is only honoured while busy is high.
  logic [3:0] key_value;
  logic       key_valid;
  logic [7:0] dp_data;
  logic       dp_a_load;
  logic       dp_b_load;
  logic [1:0] dp_op;
  logic       dp_start;
  logic       dp_done;
  logic [7:0] dp_result;
  logic [7:0] outreg_data;
  logic [3:0] kout;
  logic       busy;
  logic       err;
  logic [2:0] dbg_state;

  modport master (
    input  key_value, key_valid, dp_done, dp_result,
    output dp_data, dp_a_load, dp_b_load, dp_op, dp_start,
           outreg_data, kout, busy, err, dbg_state
  );

  modport slave (
    output key_value, key_valid, dp_done, dp_result,
    input  dp_data, dp_a_load, dp_b_load, dp_op, dp_start,
           outreg_data, kout, busy, err, dbg_state
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// Calculator control FSM: qualifies held keys into single commands and
// sequences operand loads, ALU start and result write-back.
module calc_key_sequencer #(
  parameter int HOLD_MIN = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 reset_p,
  calc_key_sequencer_if.master bus
);

  localparam int HW = $clog2(HOLD_MIN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MIN);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MIN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPND_A = 3'd1,
    S_WAIT_B = 3'd2,
    S_OPND_B = 3'd3,
    S_EXEC   = 3'd4
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          armed;
  logic [TW-1:0] tmr;

  logic       accept;
  logic       is_digit;
  logic       is_oper;
  logic       is_clear;
  logic       is_equals;
  logic [3:0] op_diff;
  logic [1:0] op_code;
  logic [7:0] digit_ext;

  // The accept cycle is the one on which the counter would reach HOLD_MIN.
  assign accept    = bus.key_valid && armed && (hold_cnt == HOLD_LAST);
  assign is_digit  = (bus.key_value <= 4'd9);
  assign is_oper   = (bus.key_value >= 4'd10) && (bus.key_value <= 4'd13);
  assign is_clear  = (bus.key_value == 4'd14);
  assign is_equals = (bus.key_value == 4'd15);
  assign op_diff   = bus.key_value - 4'd10;
  assign op_code   = op_diff[1:0];
  assign digit_ext = {4'd0, bus.key_value};

  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state           <= S_IDLE;
      hold_cnt        <= '0;
      armed           <= 1'b1;
      tmr             <= '0;
      bus.dp_data     <= '0;
      bus.dp_a_load   <= 1'b0;
      bus.dp_b_load   <= 1'b0;
      bus.dp_op       <= '0;
      bus.dp_start    <= 1'b0;
      bus.outreg_data <= '0;
      bus.kout        <= '0;
      bus.busy        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      bus.dp_a_load <= 1'b0;
      bus.dp_b_load <= 1'b0;
      bus.dp_start  <= 1'b0;

      if (!bus.key_valid) begin
        hold_cnt <= '0;
        armed    <= 1'b1;
      end else begin
        if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + HW'(1);
        if (accept) armed <= 1'b0;
      end

      if (accept && is_clear) begin
        // Clear aborts everything, including an ALU operation in flight.
        bus.kout        <= bus.key_value;
        bus.err         <= 1'b0;
        bus.outreg_data <= '0;
        bus.busy        <= 1'b0;
        state           <= S_IDLE;
      end else if (state == S_EXEC) begin
        if (bus.dp_done) begin
          bus.outreg_data <= bus.dp_result;
          bus.busy        <= 1'b0;
          state           <= S_IDLE;
        end else if (tmr == TMO_LAST) begin
          bus.err  <= 1'b1;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end else begin
          tmr <= tmr + TW'(1);
        end
      end else if (accept) begin
        bus.kout <= bus.key_value;
        bus.err  <= 1'b0;
        case (state)
          S_IDLE: begin
            if (is_digit) begin
              bus.dp_data     <= digit_ext;
              bus.dp_a_load   <= 1'b1;
              bus.outreg_data <= digit_ext;
              state           <= S_OPND_A;
            end else if (is_oper) begin
              // Chain the previous result in as operand A.
              bus.dp_data   <= bus.outreg_data;
              bus.dp_a_load <= 1'b1;
              bus.dp_op     <= op_code;
              state         <= S_WAIT_B;
            end
          end
          S_OPND_A: begin
            if (is_digit) begin
              bus.dp_data     <= digit_ext;
              bus.dp_a_load   <= 1'b1;
              bus.outreg_data <= digit_ext;
            end else if (is_oper) begin
              bus.dp_op <= op_code;
              state     <= S_WAIT_B;
            end
          end
          S_WAIT_B: begin
            if (is_digit) begin
              bus.dp_data     <= digit_ext;
              bus.dp_b_load   <= 1'b1;
              bus.outreg_data <= digit_ext;
              state           <= S_OPND_B;
            end else if (is_oper) begin
              bus.dp_op <= op_code;
            end
          end
          S_OPND_B: begin
            if (is_digit) begin
              bus.dp_data     <= digit_ext;
              bus.dp_b_load   <= 1'b1;
              bus.outreg_data <= digit_ext;
            end else if (is_equals) begin
              bus.dp_start <= 1'b1;
              bus.busy     <= 1'b1;
              tmr          <= '0;
              state        <= S_EXEC;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
